// File: rtl/dac7611_serial_rx.sv
// Loopback receiver for the DAC7611 3-wire load interface: rebuilds 12-bit
// MSB-first words from the header lines, latches them on LD and flags bad frames.
module dac7611_serial_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_i,
  input  logic             sdi_i,
  input  logic             ld_n_i,
  input  logic             clr_n_i,
  output logic [11:0]      dac_code_o,
  output logic             code_valid_o,
  output logic             clr_seen_o,
  output logic             len_err_o,
  output logic             edge_err_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [7:0]       err_cnt_o
);

  // state   | meaning
  // IDLE    | no bits since last load (bit_cnt = 0)
  // SHIFT   | at least one bit received, LD high
  // HOLD    | LD low; sclk rises here are errors
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Synchronizer bit order: {clr_n, ld_n, sdi, sclk}; resets high so no false edges.
  logic [3:0] sync_q [SYNC_STAGES];
  logic [2:0] prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'hF;
      prev_q <= 3'b111;
    end else begin
      sync_q[0] <= {clr_n_i, ld_n_i, sdi_i, sclk_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= {sync_q[SYNC_STAGES-1][3], sync_q[SYNC_STAGES-1][2], sync_q[SYNC_STAGES-1][0]};
    end
  end

  logic sclk_s, sdi_s, ld_s, clr_s;
  assign sclk_s = sync_q[SYNC_STAGES-1][0];
  assign sdi_s  = sync_q[SYNC_STAGES-1][1];
  assign ld_s   = sync_q[SYNC_STAGES-1][2];
  assign clr_s  = sync_q[SYNC_STAGES-1][3];

  logic sclk_rise, ld_fall, ld_rise, clr_fall;
  assign sclk_rise = sclk_s & ~prev_q[0];
  assign ld_fall   = ~ld_s & prev_q[1];
  assign ld_rise   = ld_s & ~prev_q[1];
  assign clr_fall  = ~clr_s & prev_q[2];

  logic [1:0]       state_q, state_d;
  logic [11:0]      sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [11:0]      dac_code_q, dac_code_d;
  logic             code_valid_q, clr_seen_q, len_err_q, edge_err_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // An edge is judged against the current LD level, so a simultaneous LD fall rejects it.
  logic shift_en, edge_bad, load, len_bad, good;
  logic [8:0] err_sum;
  assign shift_en = sclk_rise & ld_s;
  assign edge_bad = sclk_rise & ~ld_s;
  assign load     = ld_fall & clr_s;
  assign good     = load & (bit_cnt_q == 4'd12);
  assign len_bad  = load & (bit_cnt_q != 4'd12);
  assign err_sum  = {1'b0, err_cnt_q} + {8'd0, len_bad} + {8'd0, edge_bad};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    dac_code_d  = dac_code_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];

    if (shift_en) begin
      sr_d = {sr_q[10:0], sdi_s};
      if (bit_cnt_q != 4'd15) bit_cnt_d = bit_cnt_q + 4'd1;
    end
    if (ld_fall) bit_cnt_d = 4'd0;
    if (load) dac_code_d = sr_q;
    if (good) frame_cnt_d = frame_cnt_q + 1'b1;
    if (!clr_s) dac_code_d = 12'h000;

    case (state_q)
      ST_IDLE:  if (ld_fall) state_d = ST_HOLD; else if (shift_en) state_d = ST_SHIFT;
      ST_SHIFT: if (ld_fall) state_d = ST_HOLD;
      ST_HOLD:  if (ld_rise) state_d = shift_en ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sr_q         <= 12'h000;
      bit_cnt_q    <= 4'd0;
      dac_code_q   <= 12'h000;
      code_valid_q <= 1'b0;
      clr_seen_q   <= 1'b0;
      len_err_q    <= 1'b0;
      edge_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      dac_code_q   <= dac_code_d;
      code_valid_q <= load;
      clr_seen_q   <= clr_fall;
      len_err_q    <= len_bad;
      edge_err_q   <= edge_bad;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign dac_code_o   = dac_code_q;
  assign code_valid_o = code_valid_q;
  assign clr_seen_o   = clr_seen_q;
  assign len_err_o    = len_err_q;
  assign edge_err_o   = edge_err_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_dac7611_serial_rx.sv
// Scoreboard bench for dac7611_serial_rx: a bit-history model predicts every
// output pulse; a negedge monitor pops and compares each one.
module tb_dac7611_serial_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk, sdi, ld_n, clr_n;
  logic [11:0] dac_code;
  logic        code_valid, clr_seen, len_err, edge_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  dac7611_serial_rx #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .sclk_i(sclk), .sdi_i(sdi), .ld_n_i(ld_n), .clr_n_i(clr_n),
    .dac_code_o(dac_code), .code_valid_o(code_valid), .clr_seen_o(clr_seen),
    .len_err_o(len_err), .edge_err_o(edge_err), .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        cv, len, edg, clr;
    bit [11:0] code;
    int        fcnt, ecnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  // Model: bits received (last 12 kept), bits since last load, output registers.
  bit        hist[$];
  int        m_n, m_f, m_e;
  bit [11:0] m_dac;

  function automatic bit [11:0] m_code();
    bit [11:0] c = '0;
    for (int i = 0; i < 12; i++) begin
      int idx = hist.size() - 12 + i;
      c[11-i] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return c;
  endfunction

  function automatic int sat_add(int a, int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_n = 0; m_f = 0; m_e = 0; m_dac = '0;
  endfunction

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (code_valid || len_err || edge_err || clr_seen)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cv=%0b len=%0b edge=%0b clr=%0b code=%h with nothing expected",
                 code_valid, len_err, edge_err, clr_seen, dac_code);
      end else begin
        e = exp_q.pop_front();
        if (code_valid !== e.cv || len_err !== e.len || edge_err !== e.edg || clr_seen !== e.clr ||
            dac_code !== e.code || int'(frame_cnt) != e.fcnt || int'(err_cnt) != e.ecnt) begin
          errors++;
          $display("FAIL event: got cv=%0b len=%0b edge=%0b clr=%0b code=%h fcnt=%0d ecnt=%0d, expected cv=%0b len=%0b edge=%0b clr=%0b code=%h fcnt=%0d ecnt=%0d",
                   code_valid, len_err, edge_err, clr_seen, dac_code, frame_cnt, err_cnt,
                   e.cv, e.len, e.edg, e.clr, e.code, e.fcnt, e.ecnt);
        end
      end
    end
  end

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(bit b);
    sclk = 1'b0; sdi = b;
    wait_clk(2);
    sclk = 1'b1;
    wait_clk(2);
    hist.push_back(b);
    if (hist.size() > 12) void'(hist.pop_front());
    m_n++;
  endtask

  task automatic send_word(logic [15:0] val, int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(val[i]);
  endtask

  task automatic push_load();
    int c = (m_n > 15) ? 15 : m_n;
    bit [11:0] code = m_code();
    if (c == 12) m_f++; else m_e = sat_add(m_e, 1);
    m_dac = code;
    m_n = 0;
    exp_q.push_back('{cv: 1, len: (c != 12), edg: 0, clr: 0, code: code, fcnt: m_f, ecnt: m_e});
  endtask

  task automatic pulse_ld(bit chk_lat);
    push_load();
    ld_n = 1'b0;
    if (chk_lat) begin
      wait_clk(2);
      chk("latency_early", code_valid, 0);
      wait_clk(1);
      chk("latency_on", code_valid, 1);
      wait_clk(1);
      chk("pulse_width", code_valid, 0);
    end else begin
      wait_clk(2);
    end
    ld_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic ld_with_edge();
    push_load();
    ld_n = 1'b0;
    wait_clk(3);
    sclk = 1'b0;
    wait_clk(2);
    m_e = sat_add(m_e, 1);
    exp_q.push_back('{cv: 0, len: 0, edg: 1, clr: 0, code: m_dac, fcnt: m_f, ecnt: m_e});
    sclk = 1'b1;
    wait_clk(3);
    ld_n = 1'b1;
    wait_clk(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, e0, r;
    reset = 1'b1; sclk = 1'b1; sdi = 1'b0; ld_n = 1'b1; clr_n = 1'b1;
    model_reset();
    wait_clk(3);
    chk("reset_dac", dac_code, 0);
    chk("reset_frame", frame_cnt, 0);
    chk("reset_err", err_cnt, 0);
    chk("reset_pulses", {code_valid, clr_seen, len_err, edge_err}, 0);
    reset = 1'b0;
    wait_clk(3);

    send_word(16'h555, 12);
    pulse_ld(1'b1);
    chk("load_555", dac_code, 12'h555);
    chk("frame_after_555", frame_cnt, 1);
    chk("err_after_555", err_cnt, 0);

    clr_n = 1'b0;
    m_dac = '0;
    exp_q.push_back('{cv: 0, len: 0, edg: 0, clr: 1, code: 12'h000, fcnt: m_f, ecnt: m_e});
    wait_clk(4);
    chk("clr_hold", dac_code, 0);
    clr_n = 1'b1;
    wait_clk(4);
    chk("clr_after", dac_code, 0);

    send_word(16'hABC, 12);
    pulse_ld(1'b0);
    chk("load_abc", dac_code, 12'hABC);

    send_word(16'h2AA, 11);
    pulse_ld(1'b0);
    chk("short_err", err_cnt, 1);
    chk("short_frame", frame_cnt, 2);
    send_word(16'h1FFE, 13);
    pulse_ld(1'b0);
    chk("long_code", dac_code, 12'hFFE);
    chk("long_err", err_cnt, 2);

    send_word(16'h3C5, 12);
    ld_with_edge();
    chk("edge_err_cnt", err_cnt, 3);
    send_word(16'h123, 12);
    pulse_ld(1'b0);
    chk("load_123", dac_code, 12'h123);

    send_word(16'h2A, 6);
    reset = 1'b1;
    #1;
    chk("midreset_dac", dac_code, 0);
    chk("midreset_frame", frame_cnt, 0);
    chk("midreset_err", err_cnt, 0);
    model_reset();
    wait_clk(2);
    reset = 1'b0;
    wait_clk(3);
    send_word(16'h800, 12);
    pulse_ld(1'b0);
    chk("load_800", dac_code, 12'h800);
    chk("frame_after_reset", frame_cnt, 1);

    send_word(16'h7E1, 12);
    f0 = m_f; e0 = m_e;
    ld_n = 1'b0; clr_n = 1'b0;
    m_n = 0; m_dac = '0;
    exp_q.push_back('{cv: 0, len: 0, edg: 0, clr: 1, code: 12'h000, fcnt: m_f, ecnt: m_e});
    wait_clk(4);
    ld_n = 1'b1; clr_n = 1'b1;
    wait_clk(4);
    chk("simul_dac", dac_code, 0);
    chk("simul_frame", frame_cnt, f0);
    chk("simul_err", err_cnt, e0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        6:       send_word(16'($urandom), 11);
        7:       send_word(16'($urandom), 13);
        8:       ;
        default: send_word(16'($urandom), 12);
      endcase
      if (r == 9) ld_with_edge(); else pulse_ld(1'b0);
    end

    for (int k = 0; k < 256; k++) pulse_ld(1'b0);
    chk("err_saturate", err_cnt, 255);
    send_word(16'h0F0, 11);
    pulse_ld(1'b0);
    chk("err_stuck", err_cnt, 255);

    wait_clk(4);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
